sbit_align_sequencer: RTL and testbench

SBIT_ALIGN_SEQUENCER -- requirements
Module: sbit_align_sequencer

---
 rtl/sbit_align_sequencer.sv | 146 ++++++++++++++
 tb/tb_sbit_align_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbit_align_sequencer.sv
// sbit_align_sequencer: round-robin realignment of VFAT frame aligners via per-VFAT reset pulses
//   clock          40 MHz LHC clock, the only clock
//   reset_n        synchronous active-low reset
//   enable         run enable; low parks the sequencer in IDLE
//   vfat_mask      1 excludes a VFAT from service
//   sof_is_aligned per-VFAT aligned flag from the frame aligners
//   sof_unstable   per-VFAT sticky lost-alignment flag
//   lock_timeout   cycles to wait for lock after each reset pulse (0 treated as 1)
//   clear_failed   pulse clearing align_failed
//   frame_reset    one-hot (or zero) reset to the frame aligners
//   busy           high while pulsing or waiting for lock
//   cur_vfat       scan pointer
//   align_failed   sticky per-VFAT give-up flag
//   relock_count   saturating count of successful relocks
//   all_aligned    every unmasked VFAT aligned and stable
module sbit_align_sequencer #(
    parameter int MXVFATS      = 24,
    parameter int RESET_CYCLES = 16,
    parameter int MAX_RETRIES  = 7
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [MXVFATS-1:0] vfat_mask,
    input  logic [MXVFATS-1:0] sof_is_aligned,
    input  logic [MXVFATS-1:0] sof_unstable,
    input  logic [11:0]        lock_timeout,
    input  logic               clear_failed,
    output logic [MXVFATS-1:0] frame_reset,
    output logic               busy,
    output logic [4:0]         cur_vfat,
    output logic [MXVFATS-1:0] align_failed,
    output logic [15:0]        relock_count,
    output logic               all_aligned
);
    typedef enum logic [1:0] {IDLE, SCAN, RESET, WAIT} state_t;
    state_t state;
    logic [15:0] pulse_cnt;
    logic [11:0] wait_cnt;
    logic [11:0] tmo;
    logic [2:0]  retries;
    logic [MXVFATS-1:0] sel;
    logic [MXVFATS-1:0] fail_set;
    logic [4:0]  next_ptr;
    logic        masked;
    logic        good;
    logic        need_service;
    logic        pulse_done;
    logic        timed_out;
    logic        last_try;
    assign sel          = {{(MXVFATS-1){1'b0}}, 1'b1} << cur_vfat;
    assign masked       = vfat_mask[cur_vfat];
    assign good         = sof_is_aligned[cur_vfat] & ~sof_unstable[cur_vfat];
    assign need_service = ~masked & ~align_failed[cur_vfat] & ~good;
    assign next_ptr     = (cur_vfat == 5'(MXVFATS-1)) ? 5'd0 : cur_vfat + 5'd1;
    assign pulse_done   = pulse_cnt == 16'(RESET_CYCLES-1);
    // wait_cnt counts elapsed WAIT cycles, so the wait lasts exactly tmo cycles
    assign timed_out    = (wait_cnt + 12'd1) == tmo;
    assign last_try     = (retries + 3'd1) == 3'(MAX_RETRIES);
    // success and mask abort both pre-empt a give-up in the same cycle
    assign fail_set     = (enable && state == WAIT && !masked && !good && timed_out && last_try) ? sel : '0;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            frame_reset  <= '0;
            busy         <= 1'b0;
            cur_vfat     <= 5'd0;
            align_failed <= '0;
            relock_count <= 16'd0;
            all_aligned  <= 1'b0;
            retries      <= 3'd0;
            pulse_cnt    <= 16'd0;
            wait_cnt     <= 12'd0;
            tmo          <= 12'd0;
        end else begin
            all_aligned  <= &(sof_is_aligned | vfat_mask) & ~|(sof_unstable & ~vfat_mask);
            // a bit being set in the same cycle as clear_failed survives
            align_failed <= (clear_failed ? '0 : align_failed) | fail_set;
            if (!enable) begin
                state       <= IDLE;
                frame_reset <= '0;
                busy        <= 1'b0;
                retries     <= 3'd0;
            end else begin
                case (state)
                    IDLE: state <= SCAN;
                    SCAN: begin
                        if (need_service) begin
                            state       <= RESET;
                            pulse_cnt   <= 16'd0;
                            frame_reset <= sel;
                            busy        <= 1'b1;
                        end else begin
                            cur_vfat <= next_ptr;
                        end
                    end
                    RESET: begin
                        if (masked) begin
                            state       <= SCAN;
                            frame_reset <= '0;
                            busy        <= 1'b0;
                            retries     <= 3'd0;
                            cur_vfat    <= next_ptr;
                        end else if (pulse_done) begin
                            state       <= WAIT;
                            frame_reset <= '0;
                            wait_cnt    <= 12'd0;
                            tmo         <= (lock_timeout == 12'd0) ? 12'd1 : lock_timeout;
                        end else begin
                            pulse_cnt <= pulse_cnt + 16'd1;
                        end
                    end
                    WAIT: begin
                        if (masked) begin
                            state    <= SCAN;
                            busy     <= 1'b0;
                            retries  <= 3'd0;
                            cur_vfat <= next_ptr;
                        end else if (good) begin
                            state        <= SCAN;
                            busy         <= 1'b0;
                            retries      <= 3'd0;
                            cur_vfat     <= next_ptr;
                            relock_count <= (relock_count == 16'hFFFF) ? relock_count : relock_count + 16'd1;
                        end else if (timed_out) begin
                            if (last_try) begin
                                state    <= SCAN;
                                busy     <= 1'b0;
                                retries  <= 3'd0;
                                cur_vfat <= next_ptr;
                            end else begin
                                state       <= RESET;
                                retries     <= retries + 3'd1;
                                pulse_cnt   <= 16'd0;
                                frame_reset <= sel;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 12'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sbit_align_sequencer.sv
// tb_sbit_align_sequencer: directed stimulus with queued expectations checked by output monitors
module tb_sbit_align_sequencer;
    localparam int N = 24;
    typedef struct {
        int vfat;
        int width;
        int gap;
    } pulse_t;
    logic         clock = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         clear_failed;
    logic [N-1:0] vfat_mask;
    logic [N-1:0] sof_is_aligned;
    logic [N-1:0] sof_unstable;
    logic [11:0]  lock_timeout;
    logic [N-1:0] frame_reset;
    logic         busy;
    logic [4:0]   cur_vfat;
    logic [N-1:0] align_failed;
    logic [15:0]  relock_count;
    logic         all_aligned;
    int vectors = 0;
    int fails = 0;
    bit mon_on = 1'b0;
    pulse_t       pulse_q[$];
    logic [15:0]  relock_q[$];
    logic [N-1:0] failed_q[$];
    pulse_t       exp_p;
    int run_w = 0;
    int low_run = 1000;
    int pulse_gap = 0;
    int pulse_vfat = 0;
    logic [15:0]  prev_r = '0;
    logic [N-1:0] prev_a = '0;

    sbit_align_sequencer dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .vfat_mask(vfat_mask),
        .sof_is_aligned(sof_is_aligned), .sof_unstable(sof_unstable),
        .lock_timeout(lock_timeout), .clear_failed(clear_failed),
        .frame_reset(frame_reset), .busy(busy), .cur_vfat(cur_vfat),
        .align_failed(align_failed), .relock_count(relock_count), .all_aligned(all_aligned)
    );

    always #12 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pulse(input int v, input int w, input int g);
        pulse_t p;
        p.vfat = v;
        p.width = w;
        p.gap = g;
        pulse_q.push_back(p);
    endtask

    // kind 0: frame_reset[idx], 1: align_failed[idx], 2: busy
    task automatic wait_for(input int kind, input int idx, input logic lvl, input int budget, input string what);
        logic v;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            v = (kind == 0) ? frame_reset[idx] : (kind == 1) ? align_failed[idx] : busy;
            if (v === lvl) return;
        end
        vectors++;
        fails++;
        $display("FAIL %s: not seen within %0d cycles", what, budget);
    endtask

    // pulse monitor: measures each frame_reset pulse and the low gap before it
    always @(negedge clock) begin
        if (mon_on) begin
            if (frame_reset != '0) begin
                if ($countones(frame_reset) != 1) begin
                    vectors++;
                    fails++;
                    $display("FAIL onehot: frame_reset=%h expected at most one bit", frame_reset);
                end
                if (run_w == 0) begin
                    pulse_gap = low_run;
                    pulse_vfat = $clog2(frame_reset);
                end
                run_w++;
            end else begin
                if (run_w != 0) begin
                    if (pulse_q.size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL pulse: unexpected pulse vfat %0d width %0d expected none", pulse_vfat, run_w);
                    end else begin
                        exp_p = pulse_q.pop_front();
                        check("pulse_vfat", pulse_vfat, exp_p.vfat);
                        check("pulse_width", run_w, exp_p.width);
                        if (exp_p.gap >= 0) check("pulse_gap", pulse_gap, exp_p.gap);
                    end
                    low_run = 0;
                end
                run_w = 0;
                low_run++;
            end
        end
    end

    // relock_count / align_failed monitor: every change must match the next queued value
    always @(negedge clock) begin
        if (mon_on) begin
            if (relock_count !== prev_r) begin
                if (relock_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL relock_count: got %0h expected unchanged %0h", relock_count, prev_r);
                end else check("relock_count", relock_count, relock_q.pop_front());
                prev_r = relock_count;
            end
            if (align_failed !== prev_a) begin
                if (failed_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL align_failed: got %h expected unchanged %h", align_failed, prev_a);
                end else check("align_failed", align_failed, failed_q.pop_front());
                prev_a = align_failed;
            end
        end
    end

    initial begin
        #(24 * 20000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int bad;
        int wraps;
        reset_n = 1'b0;
        enable = 1'b0;
        clear_failed = 1'b0;
        vfat_mask = '0;
        sof_is_aligned = '1;
        sof_unstable = '0;
        lock_timeout = 12'd100;
        repeat (3) @(negedge clock);
        check("rst_frame_reset", frame_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_vfat", cur_vfat, 0);
        check("rst_align_failed", align_failed, 0);
        check("rst_relock_count", relock_count, 0);
        check("rst_all_aligned", all_aligned, 0);
        mon_on = 1'b1;
        // all aligned: pointer sweeps and wraps, no pulses
        reset_n = 1'b1;
        enable = 1'b1;
        @(negedge clock);
        prev = int'(cur_vfat);
        bad = 0;
        wraps = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (int'(cur_vfat) != prev) begin
                if (int'(cur_vfat) != ((prev == N - 1) ? 0 : prev + 1)) bad++;
                if (prev == N - 1 && cur_vfat == 5'd0) wraps++;
            end
            if (int'(cur_vfat) > N - 1) bad++;
            prev = int'(cur_vfat);
        end
        check("scan_sequence_errors", bad, 0);
        check("scan_wrapped", wraps > 0, 1);
        check("scan_cur_vfat", cur_vfat, 12);
        check("all_aligned_set", all_aligned, 1);
        check("idle_frame_reset", frame_reset, 0);
        // VFAT 5 relocks 10 cycles after its pulse
        push_pulse(5, 16, -1);
        relock_q.push_back(16'd1);
        sof_is_aligned[5] = 1'b0;
        wait_for(0, 5, 1'b1, 40, "vfat5_pulse_start");
        wait_for(0, 5, 1'b0, 30, "vfat5_pulse_end");
        repeat (10) @(negedge clock);
        check("vfat5_busy_waiting", busy, 1);
        sof_is_aligned[5] = 1'b1;
        wait_for(2, 0, 1'b0, 20, "vfat5_relock");
        check("vfat5_align_failed", align_failed, 0);
        // VFAT 3 never aligns: 7 pulses then failed, then cleared and relocked
        lock_timeout = 12'd20;
        push_pulse(3, 16, -1);
        for (int i = 0; i < 6; i++) push_pulse(3, 16, 20);
        failed_q.push_back(24'h000008);
        sof_is_aligned[3] = 1'b0;
        wait_for(1, 3, 1'b1, 400, "vfat3_failed");
        check("vfat3_busy_after_fail", busy, 0);
        check("vfat3_cur_vfat_after_fail", cur_vfat, 4);
        repeat (60) @(negedge clock);
        check("vfat3_skipped", frame_reset, 0);
        check("vfat3_skipped_busy", busy, 0);
        failed_q.push_back('0);
        push_pulse(3, 16, -1);
        relock_q.push_back(16'd2);
        clear_failed = 1'b1;
        @(negedge clock);
        clear_failed = 1'b0;
        check("clear_failed_clears", align_failed, 0);
        wait_for(0, 3, 1'b1, 40, "vfat3_retry_start");
        wait_for(0, 3, 1'b0, 30, "vfat3_retry_end");
        sof_is_aligned[3] = 1'b1;
        wait_for(2, 0, 1'b0, 5, "vfat3_relock");
        // VFAT 7 masked during WAIT aborts without counting
        lock_timeout = 12'd100;
        push_pulse(7, 16, -1);
        sof_is_aligned[7] = 1'b0;
        wait_for(0, 7, 1'b1, 40, "vfat7_pulse_start");
        wait_for(0, 7, 1'b0, 30, "vfat7_pulse_end");
        repeat (3) @(negedge clock);
        check("vfat7_busy_in_wait", busy, 1);
        vfat_mask[7] = 1'b1;
        @(negedge clock);
        check("mask_abort_frame_reset", frame_reset, 0);
        check("mask_abort_busy", busy, 0);
        check("mask_abort_cur_vfat", cur_vfat, 8);
        check("mask_abort_relock", relock_count, 2);
        vfat_mask[7] = 1'b0;
        sof_is_aligned[7] = 1'b1;
        // VFAT 2: enable dropped mid-pulse, then reset mid-pulse
        push_pulse(2, 5, -1);
        sof_is_aligned[2] = 1'b0;
        wait_for(0, 2, 1'b1, 40, "vfat2_pulse_start");
        repeat (4) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        check("disable_frame_reset", frame_reset, 0);
        check("disable_busy", busy, 0);
        check("disable_cur_vfat", cur_vfat, 2);
        check("disable_relock", relock_count, 2);
        push_pulse(2, 5, -1);
        enable = 1'b1;
        wait_for(0, 2, 1'b1, 10, "vfat2_pulse_restart");
        repeat (4) @(negedge clock);
        relock_q.push_back(16'd0);
        reset_n = 1'b0;
        @(negedge clock);
        check("midreset_frame_reset", frame_reset, 0);
        check("midreset_busy", busy, 0);
        check("midreset_cur_vfat", cur_vfat, 0);
        check("midreset_relock", relock_count, 0);
        check("midreset_all_aligned", all_aligned, 0);
        repeat (2) @(negedge clock);
        check("pulse_queue_drained", pulse_q.size(), 0);
        check("relock_queue_drained", relock_q.size(), 0);
        check("failed_queue_drained", failed_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
